// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Gives NUM_REQ requesters shared access to the single write port of a register
//   bank. A requester raises req with its addr/data and holds them until it sees its
//   one-cycle ack pulse. The winner's address is decoded to a one-hot register enable
//   and its data is registered toward the bank, so one write per cycle is sustained
//   across requesters.
//
//   Build option: ARB_ROUND_ROBIN_EN
//     defined   : round-robin search starting at rr_ptr, upward with wrap
//     undefined : fixed priority, lowest eligible index wins
//
//   Ports
//     clk       in   clock, all state on posedge
//     rst       in   asynchronous active-low reset
//     req       in   [NUM_REQ]         per-requester write request
//     req_addr  in   [NUM_REQ*ADDR_W]  packed target address, slice i = requester i
//     req_data  in   [NUM_REQ*DATA_W]  packed write data, slice i = requester i
//     ack       out  [NUM_REQ]         one-hot pulse, write committed
//     wr_en     out  [NUM_REGS]        one-hot register enable (0 when idle)
//     wr_data   out  [DATA_W]          data to bank dataIn
//     busy      out  1 while in WRITE
//     wr_count  out  [COUNT_W]         completed writes, saturating
//
//   state  | meaning
//   IDLE   | no write on the bank port
//   WRITE  | wr_en/wr_data/ack driven for the latched winner
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REGS-1:0]         wr_en,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        busy,
  output logic [COUNT_W-1:0]          wr_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REGS-1:0] EN_ONE  = NUM_REGS'(1);
  localparam logic [NUM_REQ-1:0]  ACK_ONE = NUM_REQ'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REGS-1:0]  wr_en_q, wr_en_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [NUM_REQ-1:0]   elig;
  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  // The requester being acked still has req high at this edge; mask it so the
  // same write is not granted twice.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] && !(state_q == S_WRITE && winner_q == IDX_W'(i));
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Two ascending passes: indices at/above rr_ptr first, then the wrapped ones.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && elig[i] && IDX_W'(i) >= rr_ptr_q) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && elig[i] && IDX_W'(i) < rr_ptr_q) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && elig[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end
`endif

  // Next state and registered outputs. A grant in either state enters WRITE, which
  // is what gives back-to-back writes; the masking above keeps them distinct.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    ack_d     = '0;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE:  state_d = grant_vld ? S_WRITE : S_IDLE;
      S_WRITE: state_d = grant_vld ? S_WRITE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (grant_vld) begin
      winner_d  = grant_idx;
      ack_d     = ACK_ONE << grant_idx;
      wr_data_d = sel_data;
      // Addresses beyond the bank still complete the handshake but touch nothing.
      if (32'(sel_addr) < NUM_REGS) wr_en_d = EN_ONE << sel_addr;
    end
  end

  // Counted at the edge that ends the WRITE cycle, i.e. once the bank has captured it.
  always_comb begin
    count_d = count_q;
    if (state_q == S_WRITE && |wr_en_q && count_q != '1) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      winner_q  <= '0;
      ack_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
    end
  end

  assign ack      = ack_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q == S_WRITE);
  assign wr_count = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic          clk = 1'b0;
  logic          rst;

  // instance A: default geometry
  logic [3:0]    req_a;
  logic [19:0]   addr_a;
  logic [127:0]  data_a;
  logic [3:0]    ack_a;
  logic [31:0]   wr_en_a;
  logic [31:0]   wr_data_a;
  logic          busy_a;
  logic [15:0]   wr_count_a;

  // instance B: 16 registers, 5-bit address, 4-bit counter
  logic [3:0]    req_b;
  logic [19:0]   addr_b;
  logic [127:0]  data_b;
  logic [3:0]    ack_b;
  logic [15:0]   wr_en_b;
  logic [31:0]   wr_data_b;
  logic          busy_b;
  logic [3:0]    wr_count_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_addr(addr_a), .req_data(data_a),
    .ack(ack_a), .wr_en(wr_en_a), .wr_data(wr_data_a), .busy(busy_a),
    .wr_count(wr_count_a)
  );

  regfile_write_arbiter #(.NUM_REQ(4), .NUM_REGS(16), .ADDR_W(5), .DATA_W(32), .COUNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_b), .req_data(data_b),
    .ack(ack_b), .wr_en(wr_en_b), .wr_data(wr_data_b), .busy(busy_b),
    .wr_count(wr_count_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    tick();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    total_cnt++;
    if (ack_a !== 4'b0 || wr_en_a !== 32'b0 || wr_data_a !== 32'b0 || busy_a !== 1'b0)
      $display("FAIL reset_outputs ack=%b wr_en=%h wr_data=%h busy=%b, want 0", ack_a, wr_en_a, wr_data_a, busy_a);
    else pass_cnt++;
    total_cnt++;
    if (wr_count_a !== 16'd0 || wr_count_b !== 4'd0)
      $display("FAIL reset_count a=%0d b=%0d, want 0", wr_count_a, wr_count_b);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_single;
    tick();
    req_a = 4'b0010;
    addr_a[5 +: 5]   = 5'd5;
    data_a[32 +: 32] = 32'hDEADBEEF;
    tick();
    total_cnt++;
    if (wr_en_a !== 32'h0000_0020 || wr_data_a !== 32'hDEADBEEF || ack_a !== 4'b0010 || busy_a !== 1'b1)
      $display("FAIL single_write wr_en=%h wr_data=%h ack=%b busy=%b, want 00000020 deadbeef 0010 1",
               wr_en_a, wr_data_a, ack_a, busy_a);
    else pass_cnt++;
    req_a = 4'b0;
    tick();
    total_cnt++;
    if (wr_en_a !== 32'b0 || ack_a !== 4'b0 || busy_a !== 1'b0 || wr_count_a !== 16'd1)
      $display("FAIL single_idle wr_en=%h ack=%b busy=%b count=%0d, want 0 0 0 1",
               wr_en_a, ack_a, busy_a, wr_count_a);
    else pass_cnt++;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_arbitration;
    logic [31:0] exp_en;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr_a[i*5 +: 5]   = 5'(i + 1);
      data_a[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    end
    req_a = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_en = 32'h1 << (i + 1);
      total_cnt++;
      if (ack_a !== (4'b0001 << i) || wr_en_a !== exp_en || busy_a !== 1'b1 ||
          wr_data_a !== 32'h1000_0000 + 32'(i))
        $display("FAIL rr_grant%0d ack=%b wr_en=%h busy=%b data=%h, want ack=%b wr_en=%h",
                 i, ack_a, wr_en_a, busy_a, wr_data_a, 4'b0001 << i, exp_en);
      else pass_cnt++;
      req_a[i] = 1'b0;
    end
    tick();
    total_cnt++;
    if (busy_a !== 1'b0 || ack_a !== 4'b0 || wr_count_a !== 16'd4)
      $display("FAIL rr_done busy=%b ack=%b count=%0d, want 0 0 4", busy_a, ack_a, wr_count_a);
    else pass_cnt++;
  endtask
`else
  task automatic test_arbitration;
    int          w;
    logic [31:0] exp_en;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addr_a[i*5 +: 5]   = 5'(i + 1);
      data_a[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    end
    req_a = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      tick();
      w = c % 2;
      exp_en = 32'h1 << (w + 1);
      total_cnt++;
      if (ack_a !== (4'b0001 << w) || wr_en_a !== exp_en || busy_a !== 1'b1 ||
          wr_data_a !== 32'h1000_0000 + 32'(w))
        $display("FAIL fixed_grant%0d ack=%b wr_en=%h busy=%b data=%h, want ack=%b wr_en=%h",
                 c, ack_a, wr_en_a, busy_a, wr_data_a, 4'b0001 << w, exp_en);
      else pass_cnt++;
      if (c == 5) req_a = 4'b0;
    end
    tick();
    total_cnt++;
    if (busy_a !== 1'b0 || ack_a !== 4'b0 || wr_count_a !== 16'd6)
      $display("FAIL fixed_done busy=%b ack=%b count=%0d, want 0 0 6", busy_a, ack_a, wr_count_a);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_write;
    tick();
    req_a = 4'b1000;
    addr_a[15 +: 5]  = 5'd7;
    data_a[96 +: 32] = 32'hA5A5_5A5A;
    tick();
    total_cnt++;
    if (busy_a !== 1'b1 || ack_a !== 4'b1000 || wr_en_a !== 32'h80)
      $display("FAIL midrst_pre busy=%b ack=%b wr_en=%h, want 1 1000 00000080", busy_a, ack_a, wr_en_a);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (wr_en_a !== 32'b0 || ack_a !== 4'b0 || busy_a !== 1'b0 || wr_count_a !== 16'd0)
      $display("FAIL midrst_async wr_en=%h ack=%b busy=%b count=%0d, want all 0",
               wr_en_a, ack_a, busy_a, wr_count_a);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    total_cnt++;
    if (ack_a !== 4'b1000 || wr_en_a !== 32'h80 || wr_data_a !== 32'hA5A5_5A5A || busy_a !== 1'b1)
      $display("FAIL midrst_reissue ack=%b wr_en=%h data=%h busy=%b, want 1000 00000080 a5a55a5a 1",
               ack_a, wr_en_a, wr_data_a, busy_a);
    else pass_cnt++;
    req_a = 4'b0;
    tick();
    total_cnt++;
    if (busy_a !== 1'b0 || wr_count_a !== 16'd1)
      $display("FAIL midrst_done busy=%b count=%0d, want 0 1", busy_a, wr_count_a);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range;
    tick();
    req_b = 4'b0001;
    addr_b[0 +: 5]  = 5'd20;
    data_b[0 +: 32] = 32'h0000_1234;
    tick();
    total_cnt++;
    if (ack_b !== 4'b0001 || wr_en_b !== 16'b0 || busy_b !== 1'b1 || wr_data_b !== 32'h1234)
      $display("FAIL oor_write ack=%b wr_en=%h busy=%b data=%h, want 0001 0000 1 00001234",
               ack_b, wr_en_b, busy_b, wr_data_b);
    else pass_cnt++;
    req_b = 4'b0;
    tick();
    total_cnt++;
    if (wr_count_b !== 4'd0 || busy_b !== 1'b0)
      $display("FAIL oor_count count=%0d busy=%b, want 0 0", wr_count_b, busy_b);
    else pass_cnt++;
    req_b = 4'b0010;
    addr_b[5 +: 5] = 5'd15;
    tick();
    total_cnt++;
    if (ack_b !== 4'b0010 || wr_en_b !== 16'h8000)
      $display("FAIL top_reg ack=%b wr_en=%h, want 0010 8000", ack_b, wr_en_b);
    else pass_cnt++;
    req_b = 4'b0;
    tick();
    total_cnt++;
    if (wr_count_b !== 4'd1)
      $display("FAIL top_reg_count count=%0d, want 1", wr_count_b);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    logic [3:0] exp_cnt;
    logic [3:0] exp_ack;
    do_reset();
    addr_b[0 +: 5] = 5'd3;
    addr_b[5 +: 5] = 5'd4;
    req_b = 4'b0011;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_cnt = (n - 1 > 15) ? 4'hF : 4'(n - 1);
      exp_ack = (n % 2 == 1) ? 4'b0001 : 4'b0010;
      total_cnt++;
      if (wr_count_b !== exp_cnt || ack_b !== exp_ack)
        $display("FAIL sat_cycle%0d count=%0d ack=%b, want %0d %b", n, wr_count_b, ack_b, exp_cnt, exp_ack);
      else pass_cnt++;
      if (n == 20) req_b = 4'b0;
    end
    tick();
    total_cnt++;
    if (wr_count_b !== 4'hF || busy_b !== 1'b0)
      $display("FAIL sat_final count=%0d busy=%b, want 15 0", wr_count_b, busy_b);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wr_count_b !== 4'hF)
      $display("FAIL sat_hold count=%0d, want 15", wr_count_b);
    else pass_cnt++;
  endtask

  initial begin
    rst    = 1'b0;
    req_a  = '0;
    addr_a = '0;
    data_a = '0;
    req_b  = '0;
    addr_b = '0;
    data_b = '0;
    #12;
    test_reset();
    test_single();
    test_arbitration();
    test_reset_mid_write();
    test_out_of_range();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
